// File: rtl/display_scan_controller_if.sv
// Bundle between a scan-controller user and display_scan_controller: buffer load,
// enables and masks in; decoder nibble, anode enables, blank flag and frame tick out.
interface display_scan_controller_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    enable;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] digits_bcd;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [3:0]              bcd_out;
   logic [NUM_DIGITS-1:0]   digit_sel;
   logic                    blank_out;
   logic                    frame_tick;

   modport master (
      output enable, load, digits_bcd, blank_mask,
      input  bcd_out, digit_sel, blank_out, frame_tick
   );

   modport slave (
      input  enable, load, digits_bcd, blank_mask,
      output bcd_out, digit_sel, blank_out, frame_tick
   );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexes one BCD-to-7-segment decoder over NUM_DIGITS common-anode digits with a
// double-buffered value and an all-dark guard between digits. Option: LEADING_ZERO_BLANK_EN.
module display_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 500,
   parameter int CNT_W        = 16
) (
   input logic                      clk,
   input logic                      reset,
   display_scan_controller_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int BUF_W = 4 * NUM_DIGITS;
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, SHOW, GUARD} state_t;

   state_t           state, nxt_state;
   logic [IDX_W-1:0] idx, nxt_idx;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic [BUF_W-1:0] shadow, nxt_shadow;
   logic [BUF_W-1:0] pending;
   logic             pend_v;
   logic             frame_start;

   function automatic logic [3:0] nibble_at(input logic [BUF_W-1:0] sh,
                                            input logic [IDX_W-1:0] i);
      nibble_at = 4'hF;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (i == IDX_W'(k)) nibble_at = sh[4*k +: 4];
   endfunction

   function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] i);
      anode_sel = '1;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (i == IDX_W'(k)) anode_sel[k] = 1'b0;
   endfunction

   // Walks from the top digit down so zero_above means "this digit and all above are 0".
   function automatic logic digit_blanked(input logic [BUF_W-1:0]      sh,
                                          input logic [IDX_W-1:0]      i,
                                          input logic [NUM_DIGITS-1:0] mask);
`ifdef LEADING_ZERO_BLANK_EN
      logic zero_above;
      zero_above = 1'b1;
`endif
      digit_blanked = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
         zero_above = zero_above & (sh[4*k +: 4] == 4'h0);
`endif
         if (i == IDX_W'(k)) begin
            digit_blanked = mask[k];
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0) digit_blanked = digit_blanked | zero_above;
`endif
         end
      end
   endfunction

   always_comb begin
      nxt_state   = state;
      nxt_idx     = idx;
      nxt_cnt     = cnt;
      nxt_shadow  = shadow;
      frame_start = 1'b0;
      if (!bus.enable) begin
         nxt_state = IDLE;
         nxt_idx   = '0;
         nxt_cnt   = '0;
      end else begin
         case (state)
            IDLE: begin
               nxt_state   = SHOW;
               nxt_idx     = '0;
               nxt_cnt     = '0;
               frame_start = 1'b1;
            end
            SHOW: begin
               if (cnt != SHOW_LAST) begin
                  nxt_cnt = cnt + 1'b1;
               end else if (GUARD_CYCLES > 0) begin
                  nxt_state = GUARD;
                  nxt_cnt   = '0;
               end else begin
                  nxt_state = SHOW;
                  nxt_cnt   = '0;
                  if (idx == IDX_LAST) begin
                     nxt_idx     = '0;
                     frame_start = 1'b1;
                  end else begin
                     nxt_idx = idx + 1'b1;
                  end
               end
            end
            GUARD: begin
               if (cnt != GUARD_LAST) begin
                  nxt_cnt = cnt + 1'b1;
               end else begin
                  nxt_state = SHOW;
                  nxt_cnt   = '0;
                  if (idx == IDX_LAST) begin
                     nxt_idx     = '0;
                     frame_start = 1'b1;
                  end else begin
                     nxt_idx = idx + 1'b1;
                  end
               end
            end
            default: nxt_state = IDLE;
         endcase
      end
      // Shadow only changes on a frame boundary, so a frame never mixes two values.
      if (frame_start && pend_v) nxt_shadow = pending;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         idx            <= '0;
         cnt            <= '0;
         shadow         <= '0;
         pending        <= '0;
         pend_v         <= 1'b0;
         bus.digit_sel  <= '1;
         bus.bcd_out    <= 4'hF;
         bus.blank_out  <= 1'b1;
         bus.frame_tick <= 1'b0;
      end else begin
         state          <= nxt_state;
         idx            <= nxt_idx;
         cnt            <= nxt_cnt;
         shadow         <= nxt_shadow;
         bus.frame_tick <= frame_start;
         // A load coinciding with a frame start keeps pend_v so it lands next frame.
         if (bus.load) begin
            pending <= bus.digits_bcd;
            pend_v  <= 1'b1;
         end else if (frame_start) begin
            pend_v  <= 1'b0;
         end
         if (nxt_state == SHOW && !digit_blanked(nxt_shadow, nxt_idx, bus.blank_mask)) begin
            bus.digit_sel <= anode_sel(nxt_idx);
            bus.bcd_out   <= nibble_at(nxt_shadow, nxt_idx);
            bus.blank_out <= 1'b0;
         end else begin
            bus.digit_sel <= '1;
            bus.bcd_out   <= 4'hF;
            bus.blank_out <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (4 digits, dwell 4, guard 1): segment table
// of expected output runs plus hand sequences for reset, tick period and mid-scan reset.
module tb_display_scan_controller;
   localparam int ND = 4;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic LZ = 1'b1;
`else
   localparam logic LZ = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   display_scan_controller_if #(.NUM_DIGITS(ND)) bus();

   display_scan_controller #(
      .NUM_DIGITS(ND), .REFRESH_DIV(4), .GUARD_CYCLES(1), .CNT_W(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      logic        en;
      logic        ld;
      logic [15:0] d;
      logic [3:0]  m;
      int          len;
      logic [3:0]  sel;
      logic [3:0]  bcd;
      logic        blk;
      logic        tick;
   } seg_t;

   seg_t tbl[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic en, input logic ld, input logic [15:0] d,
                               input logic [3:0] m, input int len, input logic [3:0] sel,
                               input logic [3:0] bcd, input logic blk, input logic tick);
      seg_t s;
      s.en = en; s.ld = ld; s.d = d; s.m = m; s.len = len;
      s.sel = sel; s.bcd = bcd; s.blk = blk; s.tick = tick;
      tbl.push_back(s);
   endfunction

   function automatic void dk(input logic en, input logic [3:0] m, input int len);
      add(en, 1'b0, 16'h0, m, len, 4'hF, 4'hF, 1'b1, 1'b0);
   endfunction

   // A zero digit above digit 0: lit with 0 normally, dark when leading-zero blanking is on.
   function automatic void zero_slot(input logic [3:0] sel, input logic ld, input logic [15:0] d);
      add(1'b1, ld, d, 4'h0, 4, LZ ? 4'hF : sel, LZ ? 4'hF : 4'h0, LZ, 1'b0);
   endfunction

   task automatic step(input logic en, input logic ld, input logic [15:0] d, input logic [3:0] m);
      bus.enable = en; bus.load = ld; bus.digits_bcd = d; bus.blank_mask = m;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [3:0] sel, input logic [3:0] bcd,
                             input logic blk, input logic tick);
      check({tag, " sel"},  32'(bus.digit_sel),  32'(sel));
      check({tag, " bcd"},  32'(bus.bcd_out),    32'(bcd));
      check({tag, " blank"}, 32'(bus.blank_out), 32'(blk));
      check({tag, " tick"}, 32'(bus.frame_tick), 32'(tick));
   endtask

   initial begin
      int n;
      bus.enable = 1'b0; bus.load = 1'b0; bus.digits_bcd = '0; bus.blank_mask = '0;

      // Frame 1: load 1234 while idle, then scan
      add(1'b0, 1'b1, 16'h1234, 4'h0, 1, 4'hF, 4'hF, 1'b1, 1'b0);
      add(1'b1, 1'b0, 16'h0, 4'h0, 4, 4'hE, 4'h4, 1'b0, 1'b1);  dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b0, 16'h0, 4'h0, 4, 4'hD, 4'h3, 1'b0, 1'b0);  dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b0, 16'h0, 4'h0, 4, 4'hB, 4'h2, 1'b0, 1'b0);  dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b0, 16'h0, 4'h0, 4, 4'h7, 4'h1, 1'b0, 1'b0);  dk(1'b1, 4'h0, 1);
      // Frame 2: load 5678 mid-frame, still shows 1234
      add(1'b1, 1'b0, 16'h0,    4'h0, 4, 4'hE, 4'h4, 1'b0, 1'b1); dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b1, 16'h5678, 4'h0, 4, 4'hD, 4'h3, 1'b0, 1'b0); dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b0, 16'h0,    4'h0, 4, 4'hB, 4'h2, 1'b0, 1'b0); dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b0, 16'h0,    4'h0, 4, 4'h7, 4'h1, 1'b0, 1'b0); dk(1'b1, 4'h0, 1);
      // Frame 3: shows 5678; load 9ABC in the frame-start cycle lands next frame
      add(1'b1, 1'b1, 16'h9ABC, 4'h0, 4, 4'hE, 4'h8, 1'b0, 1'b1); dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b0, 16'h0,    4'h0, 4, 4'hD, 4'h7, 1'b0, 1'b0); dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b0, 16'h0,    4'h0, 4, 4'hB, 4'h6, 1'b0, 1'b0); dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b0, 16'h0,    4'h0, 4, 4'h7, 4'h5, 1'b0, 1'b0); dk(1'b1, 4'h0, 1);
      // Frame 4: 9ABC with blank_mask 0100, idx 2 slot dark
      add(1'b1, 1'b0, 16'h0, 4'h4, 4, 4'hE, 4'hC, 1'b0, 1'b1); dk(1'b1, 4'h4, 1);
      add(1'b1, 1'b0, 16'h0, 4'h4, 4, 4'hD, 4'hB, 1'b0, 1'b0); dk(1'b1, 4'h4, 1);
      dk(1'b1, 4'h4, 4);                                        dk(1'b1, 4'h4, 1);
      add(1'b1, 1'b0, 16'h0, 4'h4, 4, 4'h7, 4'h9, 1'b0, 1'b0); dk(1'b1, 4'h4, 1);
      // Frame 5: enable dropped during idx 2, re-enable restarts at idx 0
      add(1'b1, 1'b0, 16'h0, 4'h0, 4, 4'hE, 4'hC, 1'b0, 1'b1); dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b0, 16'h0, 4'h0, 4, 4'hD, 4'hB, 1'b0, 1'b0); dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b0, 16'h0, 4'h0, 2, 4'hB, 4'hA, 1'b0, 1'b0); dk(1'b0, 4'h0, 3);
      add(1'b1, 1'b0, 16'h0, 4'h0, 4, 4'hE, 4'hC, 1'b0, 1'b1); dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b0, 16'h0, 4'h0, 4, 4'hD, 4'hB, 1'b0, 1'b0);
      add(1'b0, 1'b1, 16'h0045, 4'h0, 2, 4'hF, 4'hF, 1'b1, 1'b0);
      // Frame 0045, with 0000 loaded mid-frame
      add(1'b1, 1'b0, 16'h0,    4'h0, 4, 4'hE, 4'h5, 1'b0, 1'b1); dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b1, 16'h0000, 4'h0, 4, 4'hD, 4'h4, 1'b0, 1'b0); dk(1'b1, 4'h0, 1);
      zero_slot(4'hB, 1'b0, 16'h0);                               dk(1'b1, 4'h0, 1);
      zero_slot(4'h7, 1'b0, 16'h0);                               dk(1'b1, 4'h0, 1);
      // Frame 0000: digit 0 always shows 0
      add(1'b1, 1'b0, 16'h0, 4'h0, 4, 4'hE, 4'h0, 1'b0, 1'b1);   dk(1'b1, 4'h0, 1);
      zero_slot(4'hD, 1'b0, 16'h0);                               dk(1'b1, 4'h0, 1);
      zero_slot(4'hB, 1'b0, 16'h0);                               dk(1'b1, 4'h0, 1);
      zero_slot(4'h7, 1'b0, 16'h0);                               dk(1'b1, 4'h0, 1);
      add(1'b1, 1'b0, 16'h0, 4'h0, 1, 4'hE, 4'h0, 1'b0, 1'b1);

      // Reset for 3 cycles with enable low: dark throughout
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 1'b0, 16'h0, 4'h0);
         check_outs($sformatf("reset c%0d", c), 4'hF, 4'hF, 1'b1, 1'b0);
      end
      reset = 1'b0;

      foreach (tbl[i]) begin
         for (int c = 0; c < tbl[i].len; c++) begin
            step(tbl[i].en, tbl[i].ld && (c == 0), tbl[i].d, tbl[i].m);
            check_outs($sformatf("seg%0d c%0d", i, c), tbl[i].sel, tbl[i].bcd, tbl[i].blk,
                       tbl[i].tick && (c == 0));
         end
      end

      // Frame tick period, bounded at 40 cycles
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         step(1'b1, 1'b0, 16'h0, 4'h0);
         if (bus.frame_tick === 1'b1) begin
            n = c;
            break;
         end
      end
      check("tick period", 32'(n), 32'd20);

      // Reset mid-scan with a pending load: pending and pend_v must be discarded
      for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 16'h0, 4'h0);
      step(1'b1, 1'b1, 16'h4321, 4'h0);
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step(1'b1, 1'b0, 16'h0, 4'h0);
         check_outs($sformatf("midreset c%0d", c), 4'hF, 4'hF, 1'b1, 1'b0);
      end
      reset = 1'b0;
      step(1'b1, 1'b0, 16'h0, 4'h0);
      check_outs("post-reset c0", 4'hE, 4'h0, 1'b0, 1'b1);
      for (int c = 1; c < 4; c++) begin
         step(1'b1, 1'b0, 16'h0, 4'h0);
         check_outs($sformatf("post-reset c%0d", c), 4'hE, 4'h0, 1'b0, 1'b0);
      end
      step(1'b1, 1'b0, 16'h0, 4'h0);
      check_outs("post-reset guard", 4'hF, 4'hF, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
